ring_decoder: RTL and testbench

Receive-side companion to the 8-bit ring counter. It samples a rotating one-hot word and validates it. It converts the word to a binary index, checks that each sample is exactly one rotation step after the last, and reports code and sequence errors. It sits downstream of any ring-counter source (on-board or external pins) and drives status LEDs and the segment display with the decoded position.

---
 rtl/ring_decoder_pkg.sv | 14 +
 rtl/ring_onehot_enc.sv | 21 ++
 rtl/ring_decoder.sv | 132 +++++++++++++
 tb/tb_ring_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_decoder_pkg.sv
// rtl/ring_decoder_pkg.sv - shared state encodings and ring constants
package ring_decoder_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } ring_state_t;

    localparam int         RING_WIDTH_DEF = 8;
    // Same seed the ring counter loads out of reset.
    localparam logic [7:0] RING_SEED      = 8'b0000_0001;

endpackage

// File: rtl/ring_onehot_enc.sv
// rtl/ring_onehot_enc.sv - one-hot legality check and binary position encoder
module ring_onehot_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             onehot,
    output logic [IDX_W-1:0] pos
);

    always_comb begin
        onehot = ($countones(vec) == 1);
        pos    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                pos = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_decoder.sv
// rtl/ring_decoder.sv - ring word tracker: HUNT/VERIFY/LOCKED FSM with error counting
module ring_decoder
    import ring_decoder_pkg::*;
#(
    parameter int WIDTH  = RING_WIDTH_DEF,
    parameter int IDX_W  = $clog2(WIDTH),
    parameter int LOCK_N = 3,
    parameter int MISS_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             ring_vld,
    input  logic             err_clr,
    output logic [IDX_W-1:0] idx,
    output logic             idx_vld,
    output logic             locked,
    output logic             err_code,
    output logic             err_seq,
    output logic [7:0]       err_cnt
);

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    ring_state_t      state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       hit_q, hit_d;
    logic [3:0]       miss_q, miss_d;
    logic [IDX_W-1:0] idx_d;
    logic             idx_vld_d, err_code_d, err_seq_d;
    logic             onehot;
    logic [IDX_W-1:0] pos;

    ring_onehot_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
        .vec    (ring_in),
        .onehot (onehot),
        .pos    (pos)
    );

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        idx_d      = idx;
        idx_vld_d  = 1'b0;
        err_code_d = 1'b0;
        err_seq_d  = 1'b0;
        if (ring_vld) begin
            if (onehot) begin
                idx_d     = pos;
                idx_vld_d = 1'b1;
            end
            case (state_q)
                ST_HUNT: begin
                    if (onehot) begin
                        exp_d   = rotl(ring_in);
                        hit_d   = '0;
                        state_d = ST_VERIFY;
                    end else begin
                        err_code_d = 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (!onehot) begin
                        err_code_d = 1'b1;
                        state_d    = ST_HUNT;
                    end else if (ring_in == exp_q) begin
                        hit_d = hit_q + 4'd1;
                        exp_d = rotl(ring_in);
                        if (hit_q + 4'd1 == 4'(LOCK_N)) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        err_seq_d = 1'b1;
                        exp_d     = rotl(ring_in);
                        hit_d     = '0;
                    end
                end
                ST_LOCKED: begin
                    // Source is assumed free-running, so expectation advances even on a miss.
                    exp_d = rotl(exp_q);
                    if (onehot && ring_in == exp_q) begin
                        miss_d = '0;
                    end else begin
                        err_seq_d  = onehot;
                        err_code_d = !onehot;
                        miss_d     = miss_q + 4'd1;
                        if (miss_q + 4'd1 == 4'(MISS_N)) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            exp_q    <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            idx      <= '0;
            idx_vld  <= 1'b0;
            err_code <= 1'b0;
            err_seq  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            idx      <= idx_d;
            idx_vld  <= idx_vld_d;
            err_code <= err_code_d;
            err_seq  <= err_seq_d;
            if (err_clr) begin
                err_cnt <= '0;
            end else if ((err_code_d || err_seq_d) && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ring_decoder.sv
// tb/tb_ring_decoder.sv - directed and randomized bench for ring_decoder against a behavioural model
module tb_ring_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ring_in = 8'h00;
    logic       ring_vld = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] idx;
    logic       idx_vld, locked, err_code, err_seq;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model: tracking mode, expected word, streak/miss counts, outputs.
    int m_mode = 0;      // 0 searching, 1 confirming, 2 tracking
    int m_exp = 0;
    int m_streak = 0;
    int m_bad = 0;
    int m_idx = 0;
    int m_idv = 0;
    int m_locked = 0;
    int m_ec = 0;
    int m_es = 0;
    int m_cnt = 0;

    ring_decoder #(.WIDTH(8), .IDX_W(3), .LOCK_N(3), .MISS_N(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ring_in  (ring_in),
        .ring_vld (ring_vld),
        .err_clr  (err_clr),
        .idx      (idx),
        .idx_vld  (idx_vld),
        .locked   (locked),
        .err_code (err_code),
        .err_seq  (err_seq),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int rot(input int x);
        return ((x * 2) + (x / 128)) % 256;
    endfunction

    function automatic int bits_set(input int x);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (x >> i) & 1;
        return n;
    endfunction

    function automatic int bit_pos(input int x);
        for (int i = 0; i < 8; i++) if (x == (1 << i)) return i;
        return -1;
    endfunction

    task automatic model_step(input int r, input int v, input int d, input int c);
        int legal;
        m_idv = 0;
        m_ec  = 0;
        m_es  = 0;
        if (r != 0) begin
            m_mode = 0; m_exp = 0; m_streak = 0; m_bad = 0;
            m_idx = 0; m_cnt = 0; m_locked = 0;
            return;
        end
        if (v != 0) begin
            legal = (bits_set(d) == 1);
            if (legal != 0) begin
                m_idx = bit_pos(d);
                m_idv = 1;
            end
            if (m_mode == 0) begin
                if (legal != 0) begin
                    m_exp = rot(d); m_streak = 0; m_mode = 1;
                end else m_ec = 1;
            end else if (m_mode == 1) begin
                if (legal == 0) begin
                    m_ec = 1; m_mode = 0;
                end else if (d == m_exp) begin
                    m_streak++;
                    m_exp = rot(d);
                    if (m_streak == 3) begin
                        m_mode = 2; m_bad = 0;
                    end
                end else begin
                    m_es = 1; m_exp = rot(d); m_streak = 0;
                end
            end else begin
                if (d == m_exp) m_bad = 0;
                else begin
                    if (legal != 0) m_es = 1; else m_ec = 1;
                    m_bad++;
                    if (m_bad == 2) m_mode = 0;
                end
                m_exp = rot(m_exp);
            end
        end
        if (c != 0) m_cnt = 0;
        else if ((m_ec + m_es) != 0 && m_cnt < 255) m_cnt++;
        m_locked = (m_mode == 2);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input int r, input int v, input int d, input int c);
        rst      = (r != 0);
        ring_vld = (v != 0);
        ring_in  = 8'(d);
        err_clr  = (c != 0);
        @(posedge clk);
        #1;
        model_step(r, v, d, c);
        chk("idx", 32'(idx), 32'(m_idx));
        chk("idx_vld", 32'(idx_vld), 32'(m_idv));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("err_code", 32'(err_code), 32'(m_ec));
        chk("err_seq", 32'(err_seq), 32'(m_es));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        rst = 1'b0; ring_vld = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        int src;
        int sel;
        int w;

        // Reset state
        apply(1, 0, 0, 0);
        apply(1, 1, 8'h01, 1);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);

        // Clean lock
        apply(0, 1, 8'h01, 0); chk("clean_idx0", 32'(idx), 32'd0);
        apply(0, 1, 8'h02, 0); chk("clean_idx1", 32'(idx), 32'd1);
        apply(0, 1, 8'h04, 0); chk("clean_idx2", 32'(idx), 32'd2);
        chk("clean_not_yet", 32'(locked), 32'd0);
        apply(0, 1, 8'h08, 0); chk("clean_idx3", 32'(idx), 32'd3);
        chk("clean_locked", 32'(locked), 32'd1);

        // Wrap-around
        apply(0, 1, 8'h10, 0);
        apply(0, 1, 8'h20, 0);
        apply(0, 1, 8'h40, 0);
        apply(0, 1, 8'h80, 0); chk("wrap_idx7", 32'(idx), 32'd7);
        apply(0, 1, 8'h01, 0); chk("wrap_idx0", 32'(idx), 32'd0);
        chk("wrap_locked", 32'(locked), 32'd1);
        chk("wrap_cnt", 32'(err_cnt), 32'd0);

        // Illegal codes while locked
        apply(0, 1, 8'h00, 0); chk("ill_code1", 32'(err_code), 32'd1);
        chk("ill_still_locked", 32'(locked), 32'd1);
        apply(0, 1, 8'h03, 0); chk("ill_code2", 32'(err_code), 32'd1);
        chk("ill_cnt", 32'(err_cnt), 32'd2);
        chk("ill_unlocked", 32'(locked), 32'd0);
        chk("ill_idx_kept", 32'(idx), 32'd0);

        // Sequence skip during verification
        apply(0, 1, 8'h01, 0);
        apply(0, 1, 8'h02, 0);
        apply(0, 1, 8'h10, 0); chk("skip_seq", 32'(err_seq), 32'd1);
        chk("skip_idx", 32'(idx), 32'd4);
        apply(0, 1, 8'h20, 0);
        apply(0, 1, 8'h40, 0); chk("skip_not_yet", 32'(locked), 32'd0);
        apply(0, 1, 8'h80, 0); chk("skip_locked", 32'(locked), 32'd1);

        // Idle gaps, then clear racing an error
        for (int i = 0; i < 5; i++) apply(0, 0, 8'hFF, 0);
        chk("gap_locked", 32'(locked), 32'd1);
        chk("gap_cnt", 32'(err_cnt), 32'd3);
        apply(0, 1, 8'h00, 1); chk("clr_pulse", 32'(err_code), 32'd1);
        chk("clr_wins", 32'(err_cnt), 32'd0);
        apply(0, 1, 8'h02, 0);

        // Reset mid-lock with a sample present
        chk("pre_rst_locked", 32'(locked), 32'd1);
        apply(1, 1, 8'h04, 0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_idv", 32'(idx_vld), 32'd0);
        chk("mid_rst_idx", 32'(idx), 32'd0);

        // Randomized stream: mostly clean rotation with gaps, faults, clears and resets
        src = 1 << $urandom_range(0, 7);
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 15) begin
                apply(0, 0, $urandom_range(0, 255), ($urandom_range(0, 99) < 3) ? 1 : 0);
            end else if (sel < 21) begin
                w = ($urandom_range(0, 1) != 0) ? 0 : (src | rot(src));
                apply(0, 1, w, 0);
                src = rot(src);
            end else if (sel < 27) begin
                src = 1 << $urandom_range(0, 7);
                apply(0, 1, src, 0);
                src = rot(src);
            end else if (sel < 28) begin
                apply(1, 1, src, 0);
            end else begin
                apply(0, 1, src, ($urandom_range(0, 99) < 2) ? 1 : 0);
                src = rot(src);
            end
        end

        // Saturation
        apply(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) apply(0, 1, 8'h00, 0);
        chk("sat_cnt", 32'(err_cnt), 32'd255);
        apply(0, 1, 8'h00, 0);
        chk("sat_hold", 32'(err_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
